// File: rtl/mesh_term_adapter.sv
// Terminal adapter for one mesh port: inject FIFO towards the mesh, eject FIFO from the mesh,
// destination check on every ejected packet, and saturating traffic/error counters.

module mesh_term_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         rd,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         nonempty,
  output logic [W-1:0] head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

  state_t        state, state_nxt;
  logic [OW-1:0] occ, occ_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [W-1:0]  mem [DEPTH];

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    occ_nxt = occ;
    case ({wr, rd})
      2'b10:   occ_nxt = occ + OW'(1);
      2'b01:   occ_nxt = occ - OW'(1);
      default: occ_nxt = occ;
    endcase
    state_nxt = PARTIAL;
    if (occ_nxt == '0)
      state_nxt = EMPTY;
    else if (occ_nxt == OW'(DEPTH))
      state_nxt = FULL;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= EMPTY;
      occ    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_nxt;
      occ   <= occ_nxt;
      if (wr) wr_ptr <= bump(wr_ptr);
      if (rd) rd_ptr <= bump(rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end

  assign full     = (state == FULL);
  assign nonempty = (state != EMPTY);
  assign head     = nonempty ? mem[rd_ptr] : '0;
endmodule

module mesh_term_adapter #(
  parameter int         ROWS       = 4,
  parameter int         COLUMS     = 4,
  parameter int         pckg_sz    = 40,
  parameter int         fifo_depth = 4,
  parameter logic [7:0] bdcst      = 8'hFF,
  parameter int         MY_ROW     = 0,
  parameter int         MY_COL     = 1,
  parameter int         CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_push,
  input  logic [pckg_sz-1:0] in_data,
  output logic               in_full,
  output logic               pndng_i_in,
  output logic [pckg_sz-1:0] data_out_i_in,
  input  logic               popin,
  input  logic               pndng,
  input  logic [pckg_sz-1:0] data_out,
  output logic               pop,
  input  logic               out_pop,
  output logic               out_valid,
  output logic [pckg_sz-1:0] out_data,
  output logic [CNT_W-1:0]   tx_cnt,
  output logic [CNT_W-1:0]   rx_cnt,
  output logic [CNT_W-1:0]   bcst_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic               misroute
);
  localparam logic [pckg_sz-1:0] KEEP   = {{8{1'b0}}, {(pckg_sz - 8){1'b1}}};
  localparam logic [3:0]         MY_R   = 4'(MY_ROW);
  localparam logic [3:0]         MY_C   = 4'(MY_COL);
  localparam int unsigned        ROWS_U = ROWS;
  localparam int unsigned        COLS_U = COLUMS;

  logic inj_full, inj_ne, inj_wr, inj_rd;
  logic ej_full, ej_ne, ej_rd;

  // A push into a full FIFO is still accepted when the mesh pops the head in the same cycle.
  assign inj_rd = popin & inj_ne;
  assign inj_wr = in_push & (~inj_full | inj_rd);

  mesh_term_fifo #(.W(pckg_sz), .DEPTH(fifo_depth)) u_inj (
    .clk      (clk),
    .reset    (reset),
    .wr       (inj_wr),
    .rd       (inj_rd),
    .din      (in_data & KEEP),
    .full     (inj_full),
    .nonempty (inj_ne),
    .head     (data_out_i_in)
  );

  assign in_full    = inj_full;
  assign pndng_i_in = inj_ne;

  // pop looks only at the registered full state, keeping out_pop off the pop path.
  assign pop   = pndng & ~ej_full;
  assign ej_rd = out_pop & ej_ne;

  mesh_term_fifo #(.W(pckg_sz), .DEPTH(fifo_depth)) u_ej (
    .clk      (clk),
    .reset    (reset),
    .wr       (pop),
    .rd       (ej_rd),
    .din      (data_out),
    .full     (ej_full),
    .nonempty (ej_ne),
    .head     (out_data)
  );

  assign out_valid = ej_ne;

  logic [3:0] dst_r, dst_c;
  logic       in_range, is_me, is_bc;

  assign dst_r    = data_out[pckg_sz-9:pckg_sz-12];
  assign dst_c    = data_out[pckg_sz-13:pckg_sz-16];
  assign in_range = (32'(dst_r) < ROWS_U) && (32'(dst_c) < COLS_U);
  assign is_bc    = ({dst_r, dst_c} == bdcst);
  assign is_me    = in_range && (dst_r == MY_R) && (dst_c == MY_C);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      bcst_cnt <= '0;
      err_cnt  <= '0;
      drop_cnt <= '0;
      misroute <= 1'b0;
    end else begin
      if (inj_rd) tx_cnt <= sat_inc(tx_cnt);
      if (in_push && !inj_wr) drop_cnt <= sat_inc(drop_cnt);
      if (pop) begin
        if (is_bc) begin
          rx_cnt   <= sat_inc(rx_cnt);
          bcst_cnt <= sat_inc(bcst_cnt);
        end else if (is_me) begin
          rx_cnt <= sat_inc(rx_cnt);
        end else begin
          err_cnt  <= sat_inc(err_cnt);
          misroute <= 1'b1;
        end
      end
    end
  end
endmodule
